tx_mwr32_sender: RTL and testbench
==================================

TX_MWR32_SENDER -- requirements
Module: tx_mwr32_sender

Interface
REQ-001 SHALL have port trn_clk  input  1  TRN interface clock; all logic is rising-edge on it.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port tx_turn  input  1  one-cycle grant pulse from the endpoint arbiter.
REQ-004 SHALL have port tx_driven  output  1  high while this block owns the TRN TX bus.
REQ-005 SHALL have port req_valid  input  1  write request pending; held until req_ack.
REQ-006 SHALL have port req_addr  input  32  target byte address; bits [1:0] ignored.
REQ-007 SHALL have port req_len_qw  input  5  payload length in qwords, legal 1..16.
REQ-008 SHALL have port req_ack  output  1  one-cycle pulse: request taken.
REQ-009 SHALL have port cfg_completer_id  input  16  requester ID placed in header.
REQ-010 SHALL have port pl_data  input  64  FWFT payload FIFO head; low DW is sent first.
REQ-011 SHALL have port pl_rd_en  output  1  combinational pop of payload FIFO head.
REQ-012 SHALL have ports trn_td (output, 64), trn_trem_n (output, 8), trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n (outputs, 1), trn_tdst_rdy_n (input, 1): TRN TX, active-low strobes.

Function
REQ-013 SHALL send one posted 3DW memory write (MWr32) per request; length field = 2*req_len_qw DW.
REQ-014 SHALL build header DW0 = {1'b0, fmt 2'b10, type 5'b00000, 14'b0, length[9:0]}; DW1 = {cfg_completer_id, tag[7:0], lastBE 4'hF, firstBE 4'hF}; DW2 = {req_addr[31:2], 2'b00}.
REQ-015 SHALL place the earlier DW of a beat on trn_td[63:32], the later on trn_td[31:0].
REQ-016 SHALL emit N+2 beats for N qwords (q0..qN-1): beat1 {DW0,DW1} sof; beat2 {DW2,q0[31:0]}; beat k (3..N+1) {q(k-3)[63:32], q(k-2)[31:0]}; beat N+2 {q(N-1)[63:32], 32'h0} eof.
REQ-017 SHALL drive trn_trem_n = 8'h00 on all beats except the last, 8'h0F on the last.
REQ-018 SHALL keep a 32-bit hold register for the upper DW of the previous qword.
REQ-019 SHALL assert pl_rd_en in exactly the cycles where a beat is accepted (tsrc_rdy_n and tdst_rdy_n both low) and the next beat loaded is beat 2..N+1; exactly N pops per TLP.
REQ-020 SHALL use states IDLE, SEND: IDLE -> SEND on edge sampling tx_turn=1 with req_valid=1; SEND -> IDLE on edge accepting the eof beat.
REQ-021 SHALL ignore tx_turn when req_valid=0, or when already in SEND.
REQ-022 SHALL, on the IDLE->SEND edge, register tx_driven=1, req_ack=1 (one cycle), latch addr/len, and present beat1 with tsrc_rdy_n=0, tsof_n=0.
REQ-023 SHALL register all TRN outputs; on each accepted beat load the next beat on the same edge.
REQ-024 SHALL hold trn_td, trn_trem_n, sof, eof stable while trn_tdst_rdy_n=1; no pop while stalled.
REQ-025 SHALL keep trn_tsrc_rdy_n low continuously from sof to eof acceptance (no gaps).
REQ-026 SHALL, on the edge accepting eof, set tsrc_rdy_n=1, teof_n=1, tx_driven=0.
REQ-027 SHALL keep an 8-bit tag counter incremented after each TLP, wrapping 255 -> 0.
REQ-028 SHALL treat req_len_qw=0 as 16; the requester guarantees N qwords are present in the FIFO before req_valid.

Reset
REQ-029 SHALL on reset (any state, including mid-TLP) next edge: state IDLE, tx_driven=0, req_ack=0, trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_trem_n=8'h00, trn_td=0, tag=0, hold=0; pl_rd_en=0 while reset high.
REQ-030 SHALL ignore tx_turn while reset is high.

Verification
REQ-031 SHALL cover N=1, addr 0x1000_0004, id 0x0100, tdst_rdy_n=0 -> 3 beats {0x40000002,0x010000FF},{0x10000004,q0.lo},{q0.hi,0} rem 0x0F, 1 pop, tx_driven high 3 cycles.
REQ-032 SHALL cover N=16 with random tdst_rdy_n stalls -> 18 beats, length 0x020, data stable across stalls, 16 pops.
REQ-033 SHALL cover tx_turn pulse with req_valid=0 -> no outputs change; next pulse with req_valid=1 -> TLP starts one edge later.
REQ-034 SHALL cover 257 back-to-back TLPs -> tags 0..255 then 0.
REQ-035 SHALL cover reset asserted on beat 3 of N=4 -> next edge all outputs at reset values, tx_driven=0, no further pops.

Source files
------------

// File: rtl/tx_mwr32_sender_if.sv
// tx_mwr32_sender_if: request, payload FIFO and TRN TX signals of tx_mwr32_sender
interface tx_mwr32_sender_if;
    logic        tx_turn;
    logic        tx_driven;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [4:0]  req_len_qw;
    logic        req_ack;
    logic [15:0] cfg_completer_id;
    logic [63:0] pl_data;
    logic        pl_rd_en;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;
    modport master (
        input  tx_turn, req_valid, req_addr, req_len_qw, cfg_completer_id, pl_data, trn_tdst_rdy_n,
        output tx_driven, req_ack, pl_rd_en, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n
    );
    modport slave (
        output tx_turn, req_valid, req_addr, req_len_qw, cfg_completer_id, pl_data, trn_tdst_rdy_n,
        input  tx_driven, req_ack, pl_rd_en, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n
    );
endinterface

// File: rtl/tx_mwr32_sender.sv
// tx_mwr32_sender: sends one posted MWr32 TLP per request over the 64-bit TRN TX bus
module tx_mwr32_sender (
    input logic               trn_clk,
    input logic               reset,
    tx_mwr32_sender_if.master bus
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t      state;
    logic [4:0]  n;
    logic [4:0]  beat;
    logic [31:0] addr;
    logic [31:0] hold;
    logic [7:0]  tag;
    logic [4:0]  len_qw;
    logic        accept;
    assign len_qw = bus.req_len_qw == 5'd0 ? 5'd16 : bus.req_len_qw;
    assign accept = state == SEND && !bus.trn_tsrc_rdy_n && !bus.trn_tdst_rdy_n;
    // beats 1..N each pull one qword while loading the following beat
    assign bus.pl_rd_en = !reset && accept && beat <= n;
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state              <= IDLE;
            n                  <= '0;
            beat               <= '0;
            addr               <= '0;
            hold               <= '0;
            tag                <= '0;
            bus.tx_driven      <= 1'b0;
            bus.req_ack        <= 1'b0;
            bus.trn_td         <= '0;
            bus.trn_trem_n     <= 8'h00;
            bus.trn_tsof_n     <= 1'b1;
            bus.trn_teof_n     <= 1'b1;
            bus.trn_tsrc_rdy_n <= 1'b1;
        end else begin
            bus.req_ack <= 1'b0;
            if (state == IDLE) begin
                if (bus.tx_turn && bus.req_valid) begin
                    state              <= SEND;
                    n                  <= len_qw;
                    beat               <= 5'd1;
                    addr               <= bus.req_addr & 32'hFFFF_FFFC;
                    bus.tx_driven      <= 1'b1;
                    bus.req_ack        <= 1'b1;
                    bus.trn_td         <= {1'b0, 2'b10, 5'b00000, 14'b0, 4'b0, len_qw, 1'b0,
                                           bus.cfg_completer_id, tag, 8'hFF};
                    bus.trn_trem_n     <= 8'h00;
                    bus.trn_tsof_n     <= 1'b0;
                    bus.trn_teof_n     <= 1'b1;
                    bus.trn_tsrc_rdy_n <= 1'b0;
                end
            end else if (accept) begin
                beat           <= beat + 5'd1;
                bus.trn_tsof_n <= 1'b1;
                if (beat == n + 5'd2) begin
                    state              <= IDLE;
                    tag                <= tag + 8'd1;
                    bus.tx_driven      <= 1'b0;
                    bus.trn_teof_n     <= 1'b1;
                    bus.trn_tsrc_rdy_n <= 1'b1;
                end else if (beat == n + 5'd1) begin
                    bus.trn_td     <= {hold, 32'h0};
                    bus.trn_trem_n <= 8'h0F;
                    bus.trn_teof_n <= 1'b0;
                end else begin
                    // the 3DW header leaves every qword straddling two beats
                    bus.trn_td <= {beat == 5'd1 ? addr : hold, bus.pl_data[31:0]};
                    hold       <= bus.pl_data[63:32];
                end
            end
        end
    end
endmodule

// File: tb/tb_tx_mwr32_sender.sv
// tb_tx_mwr32_sender: directed self-checking bench for tx_mwr32_sender
module tb_tx_mwr32_sender;
    logic        trn_clk = 1'b0;
    logic        reset;
    logic [31:0] rd_ptr = '0;
    logic [31:0] p0;
    logic [63:0] td_before;
    int          checks = 0;
    int          passed = 0;

    tx_mwr32_sender_if bif ();
    tx_mwr32_sender dut (.trn_clk(trn_clk), .reset(reset), .bus(bif));

    always #5 trn_clk = ~trn_clk;

    // FWFT payload FIFO: qword i holds {A000_0000+i, B000_0000+i}
    assign bif.pl_data = {32'hA000_0000 + rd_ptr, 32'hB000_0000 + rd_ptr};
    always @(posedge trn_clk) if (bif.pl_rd_en) rd_ptr <= rd_ptr + 32'd1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_src_rdy"}, bif.trn_tsrc_rdy_n, 1);
        check({tag, "_sof"}, bif.trn_tsof_n, 1);
        check({tag, "_eof"}, bif.trn_teof_n, 1);
        check({tag, "_driven"}, bif.tx_driven, 0);
        check({tag, "_ack"}, bif.req_ack, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_td"}, bif.trn_td, 0);
        check({tag, "_trem"}, bif.trn_trem_n, 8'h00);
        check({tag, "_rd_en"}, bif.pl_rd_en, 0);
        check_idle(tag);
    endtask

    task automatic run_tlp(input logic [31:0] addr, input logic [4:0] len, input logic [15:0] id,
                           input bit stall, input logic [7:0] tag);
        logic [63:0] q [16];
        logic [63:0] ex [18];
        logic [63:0] prev_td;
        logic [9:0]  prev_ctl;
        logic [31:0] start;
        bit          prev_stall;
        int          nq, got, cyc, stalls, drv;
        nq = (len == 5'd0) ? 16 : int'(len);
        start = rd_ptr;
        for (int j = 0; j < nq; j++)
            q[j] = {32'hA000_0000 + start + 32'(j), 32'hB000_0000 + start + 32'(j)};
        ex[0] = {32'h4000_0000 | 32'(2 * nq), id, tag, 8'hFF};
        ex[1] = {addr & 32'hFFFF_FFFC, q[0][31:0]};
        for (int k = 3; k <= nq + 1; k++) ex[k - 1] = {q[k - 3][63:32], q[k - 2][31:0]};
        ex[nq + 1] = {q[nq - 1][63:32], 32'h0};
        @(negedge trn_clk);
        bif.req_addr = addr;
        bif.req_len_qw = len;
        bif.cfg_completer_id = id;
        bif.req_valid = 1'b1;
        bif.tx_turn = 1'b1;
        bif.trn_tdst_rdy_n = 1'b0;
        @(negedge trn_clk);
        bif.tx_turn = 1'b0;
        bif.req_valid = 1'b0;
        check("req_ack", bif.req_ack, 1);
        got = 0; cyc = 0; stalls = 0; drv = 0;
        prev_stall = 1'b0; prev_td = '0; prev_ctl = '0;
        while (got < nq + 2 && cyc < 400) begin
            if (prev_stall) begin
                check("stall_td", bif.trn_td, prev_td);
                check("stall_ctl", {bif.trn_trem_n, bif.trn_tsof_n, bif.trn_teof_n}, prev_ctl);
            end
            if (cyc == 1) check("ack_pulse", bif.req_ack, 0);
            check("src_rdy", bif.trn_tsrc_rdy_n, 0);
            if (bif.tx_driven) drv++;
            prev_stall = stall && $urandom_range(0, 2) == 0;
            bif.trn_tdst_rdy_n = prev_stall;
            if (prev_stall) stalls++;
            else begin
                check($sformatf("td_b%0d", got + 1), bif.trn_td, ex[got]);
                check("trem", bif.trn_trem_n, got == nq + 1 ? 8'h0F : 8'h00);
                check("sof", bif.trn_tsof_n, got != 0);
                check("eof", bif.trn_teof_n, got != nq + 1);
                got++;
            end
            prev_td = bif.trn_td;
            prev_ctl = {bif.trn_trem_n, bif.trn_tsof_n, bif.trn_teof_n};
            cyc++;
            @(negedge trn_clk);
        end
        bif.trn_tdst_rdy_n = 1'b0;
        check("beats", got, nq + 2);
        check("driven_cycles", drv, nq + 2 + stalls);
        check("pops", rd_ptr - start, nq);
        check_idle("end");
    endtask

    initial begin
        reset = 1'b1;
        bif.tx_turn = 1'b0;
        bif.req_valid = 1'b0;
        bif.req_addr = '0;
        bif.req_len_qw = '0;
        bif.cfg_completer_id = '0;
        bif.trn_tdst_rdy_n = 1'b1;
        repeat (3) @(negedge trn_clk);
        check_reset("por");
        reset = 1'b0;
        // single qword: header 40000002_010000FF, then 10000004_B0000000, A0000000_00000000
        run_tlp(32'h1000_0004, 5'd1, 16'h0100, 1'b0, 8'd0);
        td_before = bif.trn_td;
        @(negedge trn_clk);
        bif.tx_turn = 1'b1;
        bif.req_valid = 1'b0;
        @(negedge trn_clk);
        bif.tx_turn = 1'b0;
        check_idle("turn_no_req");
        check("turn_no_req_td", bif.trn_td, td_before);
        run_tlp(32'h2000_0007, 5'd2, 16'hCAFE, 1'b0, 8'd1);
        run_tlp(32'h8765_4320, 5'd16, 16'h1234, 1'b1, 8'd2);
        run_tlp(32'hFFFF_FFFC, 5'd0, 16'h0001, 1'b1, 8'd3);
        run_tlp(32'h0000_0010, 5'd5, 16'hA5A5, 1'b1, 8'd4);
        p0 = rd_ptr;
        @(negedge trn_clk);
        bif.req_addr = 32'h4000_0000;
        bif.req_len_qw = 5'd4;
        bif.req_valid = 1'b1;
        bif.tx_turn = 1'b1;
        bif.trn_tdst_rdy_n = 1'b0;
        @(negedge trn_clk);
        bif.tx_turn = 1'b0;
        bif.req_valid = 1'b0;
        repeat (2) @(negedge trn_clk);
        check("beat3_pops", rd_ptr - p0, 2);
        reset = 1'b1;
        bif.tx_turn = 1'b1;
        bif.req_valid = 1'b1;
        @(negedge trn_clk);
        check_reset("mid_tlp");
        @(negedge trn_clk);
        check_reset("turn_in_reset");
        check("reset_pops", rd_ptr - p0, 2);
        bif.tx_turn = 1'b0;
        bif.req_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 257; i++)
            run_tlp(32'h3000_0000 + 32'(i * 8), 5'd1, 16'hBEEF, 1'b0, 8'(i));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
